imm_pixel_mask: RTL and testbench

Image Masking Module core. Applies a rectangular pass window to a stream of 12-bit RGB444 pixels tagged with row/column coordinates. When masking is enabled (Tx=1), pixels inside the window defined by (i_offset, j_offset) and the window size pass unchanged. Pixels outside the window are replaced by a fill colour. Sits between the pixel source (frame reader) and the output/transmit stage of the accelerator.

---
 rtl/imm_pixel_mask.sv | 127 ++++++++++++
 tb/tb_imm_pixel_mask.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pixel_mask.sv
// ---------------------------------------------------------------------------
// imm_pixel_mask
//
// Purpose:
//     Rectangular pass-window mask for a stream of RGB444 pixels. Each pixel
//     arrives with its row/column coordinate and its own copy of the window
//     origin and mask enable. With the mask enabled (Tx=1), pixels inside the
//     window pass unchanged and pixels outside are replaced by FILL. With the
//     mask disabled (Tx=0), every pixel passes unchanged. The window-hit flag
//     is reported in both modes.
//
//     A single register stage gives exactly one cycle of latency. There is
//     no backpressure: a new pixel can be accepted every cycle.
//
// Parameters:
//     MASK_ROWS  window height in rows (1..512)
//     MASK_COLS  window width in columns (1..256)
//     FILL       replacement colour for masked-out pixels
//
// Ports:
//     clk           system clock, rising edge
//     rst_n         synchronous active-low reset
//     in_valid      inputs below are valid this cycle
//     pixel         input pixel {R[11:8], G[7:4], B[3:0]}
//     i_p, j_p      pixel row (0..511) / column (0..255)
//     i_offset      window top row
//     j_offset      window left column
//     Tx            1 = apply mask, 0 = bypass
//     out_valid     pixel_result / in_window carry a new pixel this cycle
//     pixel_result  masked (or bypassed) pixel
//     in_window     window-hit flag for the pixel on pixel_result
// ---------------------------------------------------------------------------
module imm_pixel_mask #(
    parameter int          MASK_ROWS = 64,
    parameter int          MASK_COLS = 64,
    parameter logic [11:0] FILL      = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] pixel,
    input  logic [8:0]  i_p,
    input  logic [7:0]  j_p,
    input  logic [8:0]  i_offset,
    input  logic [7:0]  j_offset,
    input  logic        Tx,
    output logic        out_valid,
    output logic [11:0] pixel_result,
    output logic        in_window
);

    // Window bounds are computed in widths large enough to hold
    // offset + size without overflow (511+512 and 255+256), so a window that
    // runs past the image edge is simply clipped and never wraps to zero.
    localparam int ROW_W = 11;
    localparam int COL_W = 10;

    localparam logic [ROW_W-1:0] ROWS_EXT = ROW_W'(MASK_ROWS);
    localparam logic [COL_W-1:0] COLS_EXT = COL_W'(MASK_COLS);

    logic [ROW_W-1:0] i_p_ext;
    logic [ROW_W-1:0] i_off_ext;
    logic [ROW_W-1:0] row_end;
    logic [COL_W-1:0] j_p_ext;
    logic [COL_W-1:0] j_off_ext;
    logic [COL_W-1:0] col_end;

    logic row_hit;
    logic col_hit;
    logic hit;

    logic        out_valid_d,    out_valid_q;
    logic [11:0] pixel_result_d, pixel_result_q;
    logic        in_window_d,    in_window_q;

    // Window-hit decode. The upper bound is exclusive: the last row inside
    // is i_offset + MASK_ROWS - 1, and likewise for columns.
    always_comb begin
        i_p_ext   = ROW_W'(i_p);
        i_off_ext = ROW_W'(i_offset);
        row_end   = i_off_ext + ROWS_EXT;
        j_p_ext   = COL_W'(j_p);
        j_off_ext = COL_W'(j_offset);
        col_end   = j_off_ext + COLS_EXT;

        row_hit = (i_p_ext >= i_off_ext) && (i_p_ext < row_end);
        col_hit = (j_p_ext >= j_off_ext) && (j_p_ext < col_end);
        hit     = row_hit && col_hit;
    end

    // Next-state for the output stage. out_valid follows in_valid every
    // cycle; the data and hit flag only update on an accepted pixel so they
    // hold through bubbles.
    always_comb begin
        out_valid_d    = in_valid;
        pixel_result_d = pixel_result_q;
        in_window_d    = in_window_q;

        if (in_valid) begin
            in_window_d = hit;
            if (Tx && !hit) begin
                pixel_result_d = FILL;
            end else begin
                pixel_result_d = pixel;
            end
        end
    end

    // Output register. Reset wins over in_valid, so a pixel presented during
    // reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            pixel_result_q <= 12'h000;
            in_window_q    <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            pixel_result_q <= pixel_result_d;
            in_window_q    <= in_window_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign pixel_result = pixel_result_q;
    assign in_window    = in_window_q;

endmodule

// File: tb/tb_imm_pixel_mask.sv
// Self-checking bench for imm_pixel_mask: a table of directed vectors, a few
// hand-written multi-cycle sequences, then randomized traffic checked against
// a coordinate-arithmetic reference model.
module tb_imm_pixel_mask;

    localparam int          MASK_ROWS = 64;
    localparam int          MASK_COLS = 64;
    localparam logic [11:0] FILL      = 12'h000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] pixel;
    logic [8:0]  i_p;
    logic [7:0]  j_p;
    logic [8:0]  i_offset;
    logic [7:0]  j_offset;
    logic        Tx;
    logic        out_valid;
    logic [11:0] pixel_result;
    logic        in_window;

    int vectors_applied;
    int miscompares;

    imm_pixel_mask #(
        .MASK_ROWS(MASK_ROWS),
        .MASK_COLS(MASK_COLS),
        .FILL     (FILL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .pixel       (pixel),
        .i_p         (i_p),
        .j_p         (j_p),
        .i_offset    (i_offset),
        .j_offset    (j_offset),
        .Tx          (Tx),
        .out_valid   (out_valid),
        .pixel_result(pixel_result),
        .in_window   (in_window)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [11:0] pix;
        int          ip;
        int          jp;
        int          io;
        int          jo;
        logic        tx;
        logic        exp_v;
        logic [11:0] exp_pix;
        logic        exp_win;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic v, input logic [11:0] pix, input int ip, input int jp,
                          input int io, input int jo, input logic tx,
                          input logic ev, input logic [11:0] ep, input logic ew);
        vec_t t;
        t.v = v; t.pix = pix; t.ip = ip; t.jp = jp; t.io = io; t.jo = jo; t.tx = tx;
        t.exp_v = ev; t.exp_pix = ep; t.exp_win = ew;
        vecs.push_back(t);
    endtask

    // Drive one cycle of inputs, let the rising edge capture them, then move
    // 1 ns past the edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic v, input logic [11:0] pix, input int ip, input int jp,
                                 input int io, input int jo, input logic tx);
        in_valid = v;
        pixel    = pix;
        i_p      = 9'(ip);
        j_p      = 8'(jp);
        i_offset = 9'(io);
        j_offset = 8'(jo);
        Tx       = tx;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [11:0] ep, input logic ew);
        vectors_applied++;
        if (out_valid !== ev || pixel_result !== ep || in_window !== ew) begin
            miscompares++;
            $display("[TB] FAIL %s: got valid=%b pix=%h win=%b, expected valid=%b pix=%h win=%b",
                     name, out_valid, pixel_result, in_window, ev, ep, ew);
        end
    endtask

    // Reference: the window is the half-open range [offset, offset+size) in
    // plain integer arithmetic, which naturally clips at the image edge.
    function automatic logic model_hit(input int ip, input int jp, input int io, input int jo);
        return (ip >= io) && (ip < io + MASK_ROWS) && (jp >= jo) && (jp < jo + MASK_COLS);
    endfunction

    initial begin
        logic        m_v;
        logic [11:0] m_pix;
        logic        m_win;

        vectors_applied = 0;
        miscompares     = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        pixel    = '0;
        i_p      = '0;
        j_p      = '0;
        i_offset = '0;
        j_offset = '0;
        Tx       = 1'b0;

        // Reset state, with a valid pixel presented to show reset wins
        applyStimulus(1'b1, 12'hFFF, 0, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 12'hFFF, 0, 0, 0, 0, 1'b0);
        checkOutput("reset", 1'b0, 12'h000, 1'b0);
        rst_n = 1'b1;

        // Bypass, then hold 100 ns, then enable mask on an inside pixel
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 12'hFFF, 0, 0, 0, 0, 1'b0);
            checkOutput("bypass_hold", 1'b1, 12'hFFF, 1'b1);
        end
        applyStimulus(1'b1, 12'hFFF, 0, 0, 0, 0, 1'b1);
        checkOutput("mask_inside_fff", 1'b1, 12'hFFF, 1'b1);

        // Directed table
        addVec(1, 12'hABC,  63,  63,   0,   0, 1, 1, 12'hABC, 1);
        addVec(1, 12'hABC,  64,  10,   0,   0, 1, 1, 12'h000, 0);
        addVec(1, 12'hABC,  10,  64,   0,   0, 1, 1, 12'h000, 0);
        addVec(1, 12'hABC,  63,  63,   0,   0, 0, 1, 12'hABC, 1);
        addVec(1, 12'hABC,  64,  10,   0,   0, 0, 1, 12'hABC, 0);
        addVec(1, 12'hABC,  10,  64,   0,   0, 0, 1, 12'hABC, 0);
        addVec(1, 12'h5A5, 511, 255, 500, 250, 1, 1, 12'h5A5, 1);
        addVec(1, 12'h5A5,   3,   2, 500, 250, 1, 1, 12'h000, 0);
        addVec(1, 12'h5A5, 499, 252, 500, 250, 1, 1, 12'h000, 0);
        addVec(1, 12'h5A5, 500, 250, 500, 250, 1, 1, 12'h5A5, 1);
        addVec(0, 12'h777,   0,   0,   0,   0, 0, 0, 12'h5A5, 1);
        addVec(1, 12'h321,   0,  63,   0,   0, 1, 1, 12'h321, 1);
        addVec(1, 12'h321,   0,  64,   0,   0, 1, 1, 12'h000, 0);
        addVec(1, 12'h321,  64,   0,   0,   0, 1, 1, 12'h000, 0);
        // Back-to-back alternating hit/miss, window rows 10..73, cols 20..83
        addVec(1, 12'h111,  10,  20,  10,  20, 1, 1, 12'h111, 1);
        addVec(1, 12'h222,   9,  20,  10,  20, 1, 1, 12'h000, 0);
        addVec(1, 12'h333,  73,  83,  10,  20, 1, 1, 12'h333, 1);
        addVec(1, 12'h444,  74,  83,  10,  20, 1, 1, 12'h000, 0);
        addVec(1, 12'h555,  40,  50,  10,  20, 1, 1, 12'h555, 1);
        addVec(1, 12'h666,  10,  84,  10,  20, 1, 1, 12'h000, 0);
        addVec(1, 12'h777,  73,  20,  10,  20, 1, 1, 12'h777, 1);
        addVec(1, 12'h888,  10,  19,  10,  20, 1, 1, 12'h000, 0);
        addVec(0, 12'h999,  40,  50,  10,  20, 1, 0, 12'h000, 0);
        addVec(1, 12'hAAA,  40,  50,  10,  20, 1, 1, 12'hAAA, 1);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].v, vecs[n].pix, vecs[n].ip, vecs[n].jp,
                          vecs[n].io, vecs[n].jo, vecs[n].tx);
            checkOutput($sformatf("table[%0d]", n), vecs[n].exp_v, vecs[n].exp_pix, vecs[n].exp_win);
        end

        // Reset mid-stream with in_valid held high
        applyStimulus(1'b1, 12'hBEE, 5, 5, 0, 0, 1'b1);
        checkOutput("pre_reset", 1'b1, 12'hBEE, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b1, 12'hCAB, 5, 5, 0, 0, 1'b1);
        checkOutput("mid_reset", 1'b0, 12'h000, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 12'hBBB, 6, 6, 0, 0, 1'b1);
        checkOutput("post_reset", 1'b1, 12'hBBB, 1'b1);

        // Per-pixel Tx toggle on an outside pixel
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 12'h123, 100, 100, 0, 0, (k % 2 == 0));
            checkOutput($sformatf("tx_toggle[%0d]", k), 1'b1,
                        (k % 2 == 0) ? 12'h000 : 12'h123, 1'b0);
        end

        // Randomized traffic against the reference model
        m_v   = out_valid;
        m_pix = pixel_result;
        m_win = in_window;
        for (int k = 0; k < 400; k++) begin
            logic        r_v, r_tx, r_rst;
            logic [11:0] r_pix;
            int          r_ip, r_jp, r_io, r_jo;
            r_rst = ($urandom_range(39) == 0);
            r_v   = ($urandom_range(3) != 0);
            r_tx  = $urandom_range(1);
            r_pix = 12'($urandom);
            r_io  = $urandom_range(511);
            r_jo  = $urandom_range(255);
            if ($urandom_range(1) == 1) begin
                // Land near a window edge, clamped to the image
                r_ip = r_io + $urandom_range(MASK_ROWS + 1) - 1;
                r_jp = r_jo + $urandom_range(MASK_COLS + 1) - 1;
                if (r_ip < 0) r_ip = 0;
                if (r_ip > 511) r_ip = 511;
                if (r_jp < 0) r_jp = 0;
                if (r_jp > 255) r_jp = 255;
            end else begin
                r_ip = $urandom_range(511);
                r_jp = $urandom_range(255);
            end

            rst_n = !r_rst;
            applyStimulus(r_v, r_pix, r_ip, r_jp, r_io, r_jo, r_tx);

            if (r_rst) begin
                m_v = 1'b0; m_pix = 12'h000; m_win = 1'b0;
            end else if (r_v) begin
                m_v   = 1'b1;
                m_win = model_hit(r_ip, r_jp, r_io, r_jo);
                m_pix = (r_tx && !m_win) ? FILL : r_pix;
            end else begin
                m_v = 1'b0;
            end
            checkOutput($sformatf("random[%0d]", k), m_v, m_pix, m_win);
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
